// File: rtl/genius_ctrl.sv
// Memory-game controller: shows a growing random color sequence, then checks player presses.
// Optional GENIUS_TIMEOUT_EN: a timer-backed deadline for each expected press.
module genius_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic [1:0] level,
    output logic [1:0] timer_set,
    input  logic       timer_pronto,
    output logic [3:0] led,
    output logic [4:0] score,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        StIdle, StGen, StShowOn, StShowOff, StGap, StWaitIn, StWin, StLose
    } state_e;

    state_e      state_q, state_d;
    state_e      gap_ret_q, gap_ret_d;
    logic        gap_cnt_q, gap_cnt_d;
    logic        first_q, first_d;
    logic [4:0]  r_q, r_d;
    logic [3:0]  i_q, i_d;
    logic [1:0]  lvl_q, lvl_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  seq_q [16];
    logic        seq_we;
    logic [1:0]  seq_nx;

    logic [3:0]  led_q, led_d;
    logic [1:0]  timer_set_q, timer_set_d;
    logic [4:0]  score_q, score_d;
    logic        busy_q, busy_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic [3:0]  echo_d;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d   = state_q;
        gap_ret_d = gap_ret_q;
        gap_cnt_d = gap_cnt_q;
        first_d   = 1'b0;
        r_d       = r_q;
        i_d       = i_q;
        lvl_d     = lvl_q;
        seq_we    = 1'b0;
        score_d   = score_q;
        busy_d    = busy_q;
        win_d     = win_q;
        lose_d    = lose_q;
        echo_d    = 4'b0000;
        unique case (state_q)
            StIdle, StWin, StLose: begin
                if (start) begin
                    score_d = 5'd0;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    r_d     = 5'd0;
                    busy_d  = 1'b1;
                    lvl_d   = (level == 2'b00) ? 2'b01 : level;
                    state_d = StGen;
                end
            end
            StGen: begin
                seq_we  = 1'b1;
                r_d     = r_q + 5'd1;
                i_d     = 4'd0;
                first_d = 1'b1;
                state_d = StShowOn;
            end
            StShowOn: begin
                if (!first_q && timer_pronto) begin
                    gap_ret_d = StShowOff;
                    gap_cnt_d = 1'b0;
                    state_d   = StGap;
                end
            end
            StShowOff: begin
                if (!first_q && timer_pronto) begin
                    gap_cnt_d = 1'b0;
                    state_d   = StGap;
                    if (5'(i_q) == r_q - 5'd1) begin
                        i_d       = 4'd0;
                        gap_ret_d = StWaitIn;
                    end else begin
                        i_d       = i_q + 4'd1;
                        gap_ret_d = StShowOn;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q) begin
                    first_d = 1'b1;
                    state_d = gap_ret_q;
                end else begin
                    gap_cnt_d = 1'b1;
                end
            end
            StWaitIn: begin
                if (btn != 4'b0000) begin
                    if (btn == onehot(seq_q[i_q])) begin
                        if (5'(i_q) + 5'd1 == r_q) begin
                            // r never exceeds 16, so score saturates naturally
                            score_d = r_q;
                            i_d     = 4'd0;
                            if (r_q == 5'd16) begin
                                win_d   = 1'b1;
                                busy_d  = 1'b0;
                                state_d = StWin;
                            end else begin
                                gap_ret_d = StGen;
                                gap_cnt_d = 1'b0;
                                state_d   = StGap;
                            end
                        end else begin
                            i_d = i_q + 4'd1;
`ifdef GENIUS_TIMEOUT_EN
                            gap_ret_d = StWaitIn;
                            gap_cnt_d = 1'b0;
                            state_d   = StGap;
`else
                            echo_d = btn;
`endif
                        end
                    end else begin
                        lose_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StLose;
                    end
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (!first_q && timer_pronto) begin
                    lose_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StLose;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign seq_nx = (seq_we && (r_q[3:0] == i_d)) ? lfsr_q[1:0] : seq_q[i_d];

    always_comb begin
        led_d       = 4'b0000;
        timer_set_d = 2'b00;
        unique case (state_d)
            StShowOn: begin
                led_d       = onehot(seq_nx);
                timer_set_d = lvl_q;
            end
            StShowOff: timer_set_d = lvl_q;
            StWaitIn: begin
                led_d = echo_d;
`ifdef GENIUS_TIMEOUT_EN
                timer_set_d = 2'b11;
`endif
            end
            StWin:   led_d = 4'b1111;
            default: led_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            gap_ret_q   <= StIdle;
            gap_cnt_q   <= 1'b0;
            first_q     <= 1'b0;
            r_q         <= 5'd0;
            i_q         <= 4'd0;
            lvl_q       <= 2'b01;
            lfsr_q      <= 16'hACE1;
            led_q       <= 4'b0000;
            timer_set_q <= 2'b00;
            score_q     <= 5'd0;
            busy_q      <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_ret_q   <= gap_ret_d;
            gap_cnt_q   <= gap_cnt_d;
            first_q     <= first_d;
            r_q         <= r_d;
            i_q         <= i_d;
            lvl_q       <= lvl_d;
            lfsr_q      <= lfsr_d;
            led_q       <= led_d;
            timer_set_q <= timer_set_d;
            score_q     <= score_d;
            busy_q      <= busy_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    always_ff @(posedge clock) begin
        if (seq_we && !reset) begin
            seq_q[r_q[3:0]] <= lfsr_q[1:0];
        end
    end

    assign led       = led_q;
    assign timer_set = timer_set_q;
    assign score     = score_q;
    assign busy      = busy_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: doc/genius_ctrl.md
GENIUS_CTRL -- requirements
Module: genius_ctrl

Interface
REQ-001 SHALL have these ports, all outputs registered:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse, starts a new game
- btn  in  4  debounced player buttons, single-cycle pulses, one-hot when valid
- level  in  2  speed select forwarded to timer; 00 treated as 01
- timer_set  out  2  timer request; nonzero = start count, 00 = release/clear
- timer_pronto  in  1  timer done flag
- led  out  4  one-hot color lamp, 0 = dark
- score  out  5  rounds completed, 0..16
- busy  out  1  game in progress
- win  out  1  all 16 rounds completed
- lose  out  1  wrong press, or timeout

Function
REQ-002 SHALL implement states IDLE, GEN, SHOW_ON, SHOW_OFF, GAP, WAIT_IN, WIN, LOSE.
REQ-003 SHALL hold a 16-entry x 2-bit color sequence, a round length r (1..16) and a step index i (0..15).
REQ-004 SHALL run a 16-bit Fibonacci LFSR every cycle: seed 16'hACE1, taps 16,14,13,11; its state is never zero.
REQ-005 start in IDLE, WIN or LOSE SHALL do all of the following: clear score, win, lose and r; set busy; go to GEN.
REQ-006 start in any other state SHALL be ignored.
REQ-007 GEN (1 cycle) SHALL do all of the following: store lfsr[1:0] at sequence index r; increment r; set i=0; go to SHOW_ON.
REQ-008 led and timer_set SHALL become valid exactly 2 cycles after start is sampled.
REQ-009 In SHOW_ON, led SHALL equal one-hot(seq[i]) and timer_set SHALL equal the effective level; pronto SHALL be ignored in the first request cycle.
REQ-010 On pronto, SHOW_ON SHALL go to GAP, then SHOW_OFF.
REQ-011 SHOW_OFF SHALL run one timer interval with led=0, then go to GAP.
REQ-012 After SHOW_OFF, the controller SHALL increment i, or set i=0 and enter WAIT_IN if i==r-1.
REQ-013 GAP SHALL drive timer_set=00 and led=0 for exactly 2 cycles, so the timer returns to idle and clears pronto before the next request.
REQ-014 Every timer release SHALL pass through GAP; timer_set SHALL never change between two nonzero values directly.
REQ-015 In WAIT_IN, led SHALL echo btn for one cycle after each pulse.
REQ-016 A single-hot btn equal to one-hot(seq[i]) SHALL increment i; when i reaches r, score<=r.
REQ-017 If r==16 after a completed round, the controller SHALL go to WIN; otherwise it SHALL go to GAP, then GEN.
REQ-018 A btn not equal to one-hot(seq[i]), including multi-hot, SHALL go to LOSE; btn==0 SHALL be no event.
REQ-019 btn SHALL be ignored outside WAIT_IN.
REQ-020 WIN SHALL hold win=1, busy=0, timer_set=00 and led=4'b1111 until start or reset.
REQ-021 LOSE SHALL hold lose=1, busy=0, timer_set=00 and led=0 until start or reset.
REQ-022 win and lose SHALL never both be 1.
REQ-023 score SHALL saturate at 16 and change only on round completion.

Reset
REQ-024 reset SHALL override all other inputs, including start and btn in the same cycle.
REQ-025 reset SHALL force all of the following: state IDLE; led=0, timer_set=00, score=0, busy=0, win=0, lose=0; r=0, i=0; lfsr=16'hACE1.
REQ-026 Reset mid-show SHALL drop timer_set to 00 on the next clock edge.

Configuration
REQ-027 With GENIUS_TIMEOUT_EN defined, WAIT_IN SHALL request timer_set=11 per expected press.
REQ-028 With GENIUS_TIMEOUT_EN defined, pronto before a valid press SHALL go to LOSE.
REQ-029 With GENIUS_TIMEOUT_EN defined, a correct press SHALL pass through GAP to restart the timeout.
REQ-030 Without GENIUS_TIMEOUT_EN, WAIT_IN SHALL drive timer_set=00 and wait indefinitely.

Verification
Bench timer model: pronto rises 4 cycles after a nonzero set, clears 1 cycle after set=00.
REQ-031 Bench SHALL cover reset, then start at cycle 0, level=10 -> cycle 2: timer_set=10, led one-hot(seq[0]), busy=1.
REQ-032 Bench SHALL cover round 1 shown, then a correct btn -> score=1, GAP, round 2 shows 2 colors, seq[0] unchanged.
REQ-033 Bench SHALL cover a wrong btn or btn=4'b0011 in WAIT_IN -> lose=1, busy=0, timer_set=00 next cycle; a later start clears lose.
REQ-034 Bench SHALL cover 16 correct rounds -> win=1, score=16, led=4'b1111; btn pulses afterwards have no effect.
REQ-035 Bench SHALL cover reset asserted during SHOW_ON -> next edge: timer_set=00, led=0, state IDLE, score=0.
REQ-036 Bench SHALL cover, with GENIUS_TIMEOUT_EN, no press for the model delay -> lose=1; without it, no press for 1000 cycles -> still WAIT_IN, lose=0.
